// File: rtl/sdiv_seq_2n_by_n.sv
// Sequential signed 2N-by-N divider: restoring division on magnitudes, signs applied at the end.
// Results truncate toward zero; out-of-range quotients and zero divisors raise flags.
module sdiv_seq_2n_by_n #(
    parameter int unsigned N = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic signed [2*N-1:0] dividend,
    input  logic signed [N-1:0]   divisor,
    output logic                  busy,
    output logic                  done,
    output logic signed [N-1:0]   quotient,
    output logic signed [N-1:0]   remainder,
    output logic                  div_by_zero,
    output logic                  overflow
);

    localparam int unsigned CW = $clog2(2 * N);
    localparam logic [CW-1:0] LastIter = CW'(2 * N - 1);
    // Largest quotient magnitudes representable as signed N-bit, positive and negative.
    localparam logic [2*N-1:0] QPosMax = {{(N + 1){1'b0}}, {(N - 1){1'b1}}};
    localparam logic [2*N-1:0] QNegMax = {{N{1'b0}}, 1'b1, {(N - 1){1'b0}}};

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StFix
    } state_e;

    state_e state_q, state_d;

    logic [2*N-1:0] dvd_q;
    logic [N-1:0]   dvs_q;
    logic           sd_q;
    logic           sv_q;
    logic [2*N-1:0] quo_q;
    logic [N:0]     rem_q;
    logic [CW-1:0]  cnt_q;

    logic           done_q;
    logic [N-1:0]   quotient_q;
    logic [N-1:0]   remainder_q;
    logic           dbz_q;
    logic           ovf_q;

    logic [2*N-1:0] dvd_abs;
    logic [N-1:0]   dvs_abs;
    logic [N+1:0]   rem_shift;
    logic [N+1:0]   trial;
    logic           q_bit;
    logic [N:0]     rem_next;
    logic           neg_q;
    logic           ovf_fix;
    logic [N-1:0]   q_fix;
    logic [N-1:0]   r_fix;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (start && (divisor != '0)) state_d = StCalc;
            StCalc: if (cnt_q == LastIter) state_d = StFix;
            StFix:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        busy = (state_q != StIdle);
    end

    // Magnitudes of the operands; the most negative value maps to its unsigned magnitude.
    always_comb begin
        dvd_abs = dividend[2*N-1] ? $unsigned(-dividend) : $unsigned(dividend);
        dvs_abs = divisor[N-1] ? $unsigned(-divisor) : $unsigned(divisor);
    end

    // One restoring step: a non-negative trial difference yields a quotient bit of 1.
    always_comb begin
        rem_shift = {rem_q, dvd_q[2*N-1]};
        trial     = rem_shift - {2'b00, dvs_q};
        q_bit     = ~trial[N+1];
        rem_next  = q_bit ? trial[N:0] : rem_shift[N:0];
    end

    // Sign fix-up and range check on the final magnitudes.
    always_comb begin
        neg_q   = sd_q ^ sv_q;
        ovf_fix = neg_q ? (quo_q > QNegMax) : (quo_q > QPosMax);
        q_fix   = neg_q ? -quo_q[N-1:0] : quo_q[N-1:0];
        r_fix   = sd_q ? -rem_q[N-1:0] : rem_q[N-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd_q       <= '0;
            dvs_q       <= '0;
            sd_q        <= 1'b0;
            sv_q        <= 1'b0;
            quo_q       <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        if (divisor == '0) begin
                            done_q      <= 1'b1;
                            dbz_q       <= 1'b1;
                            ovf_q       <= 1'b0;
                            quotient_q  <= '0;
                            remainder_q <= '0;
                        end else begin
                            dvd_q <= dvd_abs;
                            dvs_q <= dvs_abs;
                            sd_q  <= dividend[2*N-1];
                            sv_q  <= divisor[N-1];
                            quo_q <= '0;
                            rem_q <= '0;
                            cnt_q <= '0;
                        end
                    end
                end
                StCalc: begin
                    dvd_q <= {dvd_q[2*N-2:0], 1'b0};
                    quo_q <= {quo_q[2*N-2:0], q_bit};
                    rem_q <= rem_next;
                    cnt_q <= cnt_q + CW'(1);
                end
                StFix: begin
                    done_q      <= 1'b1;
                    dbz_q       <= 1'b0;
                    ovf_q       <= ovf_fix;
                    quotient_q  <= ovf_fix ? '0 : q_fix;
                    remainder_q <= ovf_fix ? '0 : r_fix;
                end
                default: ;
            endcase
        end
    end

    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_sdiv_seq_2n_by_n.sv
// Directed bench for sdiv_seq_2n_by_n (N=8): hand-computed quotients, flags, latency and
// control behaviour (busy start, back-to-back, mid-operation reset).
module tb_sdiv_seq_2n_by_n;

    localparam int unsigned N = 8;

    logic                  clk;
    logic                  rst_n;
    logic                  start;
    logic signed [2*N-1:0] dividend;
    logic signed [N-1:0]   divisor;
    logic                  busy;
    logic                  done;
    logic signed [N-1:0]   quotient;
    logic signed [N-1:0]   remainder;
    logic                  div_by_zero;
    logic                  overflow;

    int checks;
    int failures;

    sdiv_seq_2n_by_n #(.N(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Counts negedges after the accepting edge until done is seen (0 = right after accept).
    task automatic wait_done(output int lat);
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input int a, input int b, input int eq,
                          input int er, input logic edz, input logic eov);
        int lat;
        @(negedge clk);
        dividend = 16'(a);
        divisor  = 8'(b);
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        dividend = 16'hffff;
        divisor  = 8'sd3;
        wait_done(lat);
        chk({tag, ".lat"}, lat, edz ? 0 : 17);
        chk({tag, ".busy"}, busy, 0);
        chk({tag, ".q"}, quotient, eq);
        chk({tag, ".r"}, remainder, er);
        chk({tag, ".dbz"}, div_by_zero, edz);
        chk({tag, ".ovf"}, overflow, eov);
        @(negedge clk);
        chk({tag, ".done_pulse"}, done, 0);
        chk({tag, ".q_hold"}, quotient, eq);
    endtask

    initial begin
        int lat;
        int dones;
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #3;
        chk("rst.busy", busy, 0);
        chk("rst.done", done, 0);
        chk("rst.q", quotient, 0);
        chk("rst.r", remainder, 0);
        chk("rst.dbz", div_by_zero, 0);
        chk("rst.ovf", overflow, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_op("50/5", 50, 5, 10, 0, 1'b0, 1'b0);
        run_op("100/-7", 100, -7, -14, 2, 1'b0, 1'b0);
        run_op("-100/7", -100, 7, -14, -2, 1'b0, 1'b0);
        run_op("-64/-8", -64, -8, 8, 0, 1'b0, 1'b0);
        run_op("-256/2", -256, 2, -128, 0, 1'b0, 1'b0);
        run_op("256/2", 256, 2, 0, 0, 1'b0, 1'b1);
        run_op("-32768/-1", -32768, -1, 0, 0, 1'b0, 1'b1);
        run_op("1234/0", 1234, 0, 0, 0, 1'b1, 1'b0);
        run_op("-7/2", -7, 2, -3, -1, 1'b0, 1'b0);

        // Start during an operation is ignored; held high through done it launches the next one.
        @(negedge clk);
        dividend = 16'sd50;
        divisor  = 8'sd5;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        dividend = 16'sd100;
        divisor  = -8'sd7;
        start    = 1'b1;
        wait_done(lat);
        chk("busy_start.lat", lat, 13);
        chk("busy_start.q", quotient, 10);
        chk("busy_start.r", remainder, 0);
        @(negedge clk);
        chk("b2b.accepted", busy, 1);
        start = 1'b0;
        wait_done(lat);
        chk("b2b.lat", lat, 17);
        chk("b2b.q", quotient, -14);
        chk("b2b.r", remainder, 2);

        // Reset mid-operation aborts with no done pulse.
        @(negedge clk);
        dividend = 16'sd50;
        divisor  = 8'sd5;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst.busy", busy, 0);
        chk("mid_rst.done", done, 0);
        chk("mid_rst.q", quotient, 0);
        chk("mid_rst.r", remainder, 0);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        repeat (25) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        chk("mid_rst.no_done", dones, 0);
        run_op("post_rst.50/5", 50, 5, 10, 0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

endmodule
